// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS fetch path.
package mips_pkg;
    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR          = 32'h0000_0000;
    localparam word_t DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int    DEFAULT_IMEM_WORDS = 256;

    // A redirect target must be word aligned and land inside instruction memory.
    function automatic logic target_legal(input word_t t, input word_t words);
        return (t[1:0] == 2'b00) && ({2'b00, t[31:2]} < words);
    endfunction
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds, load captures.
module if_id_register
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  flush,
    input  logic  stall,
    input  word_t fetch_instruction,
    input  word_t fetch_pc_plus4,
    output word_t instruction,
    output word_t pc_plus4,
    output logic  valid
);
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instruction <= NOP_INSTR;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (load && !stall) begin
            instruction <= fetch_instruction;
            pc_plus4    <= fetch_pc_plus4;
            valid       <= 1'b1;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, redirect priority, sticky fault and IF/ID stage.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter word_t RESET_PC   = DEFAULT_RESET_PC,
    parameter int    IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    input  word_t instruction,
    output word_t imem_address,
    output word_t if_id_instruction,
    output word_t if_id_pc_plus4,
    output logic  if_id_valid,
    output logic  fetch_fault,
    output word_t fetch_count
);
    localparam word_t WRAP_ADDR = word_t'(IMEM_WORDS * 4);
    localparam word_t MEM_WORDS = word_t'(IMEM_WORDS);

    word_t pc, pc_plus4, target;
    logic  redirect, legal, load, flush;

    assign imem_address = pc;
    assign pc_plus4     = pc + 32'd4;
    assign redirect     = jump | branch_taken;
    assign target       = jump ? jump_target : branch_target;
    assign legal        = target_legal(target, MEM_WORDS);
    // Once faulted, every cycle becomes a bubble until reset.
    assign flush        = fetch_fault | redirect;
    assign load         = !flush && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else if (!fetch_fault) begin
            if (redirect) begin
                if (legal) pc <= target;
                else       fetch_fault <= 1'b1;
            end else if (!stall) begin
                pc          <= (pc_plus4 == WRAP_ADDR) ? RESET_PC : pc_plus4;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_register u_if_id (
        .clk               (clk),
        .reset             (reset),
        .load              (load),
        .flush             (flush),
        .stall             (stall),
        .fetch_instruction (instruction),
        .fetch_pc_plus4    (pc_plus4),
        .instruction       (if_id_instruction),
        .pc_plus4          (if_id_pc_plus4),
        .valid             (if_id_valid)
    );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized checks of pc_fetch_unit against a behavioural fetch model.
module tb_pc_fetch_unit;
    import mips_pkg::*;

    localparam word_t RST_PC = 32'h0000_0000;
    localparam int    WORDS  = 256;

    logic  clk = 1'b0;
    logic  reset, stall, branch_taken, jump;
    word_t branch_target, jump_target, instruction;
    word_t imem_address, if_id_instruction, if_id_pc_plus4, fetch_count;
    logic  if_id_valid, fetch_fault;

    int errors = 0;
    int checks = 0;

    // Reference model state
    word_t m_pc, m_inst, m_pc4, m_count;
    logic  m_valid, m_fault;

    always #5 clk = ~clk;

    function automatic word_t mem_word(input word_t a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign instruction = mem_word(imem_address);

    pc_fetch_unit #(.RESET_PC(RST_PC), .IMEM_WORDS(WORDS)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_target       (jump_target),
        .instruction       (instruction),
        .imem_address      (imem_address),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fetch_fault       (fetch_fault),
        .fetch_count       (fetch_count)
    );

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the fetch rules, evaluated on the pre-edge model state.
    task automatic model_step(input logic r, s, b, input word_t bt, input logic j, input word_t jt);
        word_t t;
        if (r) begin
            m_pc = RST_PC; m_inst = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
        end else if (m_fault) begin
            m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (j || b) begin
            t = j ? jt : bt;
            if ((t % 4 == 0) && (t / 4 < WORDS)) m_pc = t;
            else m_fault = 1;
            m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (!s) begin
            m_inst  = mem_word(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_count = m_count + 1;
            m_pc    = (m_pc + 4 == WORDS * 4) ? RST_PC : m_pc + 4;
        end
    endtask

    task automatic step(input logic r, s, b, input word_t bt, input logic j, input word_t jt);
        @(negedge clk);
        reset = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
        @(posedge clk);
        model_step(r, s, b, bt, j, jt);
        #1;
        chk("imem_address", imem_address, m_pc);
        chk("if_id_instruction", if_id_instruction, m_inst);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        chk("fetch_count", fetch_count, m_count);
    endtask

    function automatic word_t rand_target();
        if ($urandom_range(9) == 0) return $urandom;
        return word_t'($urandom_range(WORDS - 1)) << 2;
    endfunction

    initial begin
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_count = 0; m_valid = 0; m_fault = 0;
        reset = 1; stall = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;

        // Reset and free-running fetch
        step(1, 0, 0, 0, 0, 0);
        chk("rst_addr", imem_address, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("seq_addr8", imem_address, 32'h8);
        chk("seq_pc4_8", if_id_pc_plus4, 32'h8);

        // Two-cycle stall at PC=8, then resume
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("stall_addr", imem_address, 32'h8);
        chk("stall_count", fetch_count, 32'd2);
        step(0, 0, 0, 0, 0, 0);
        chk("resume_addr", imem_address, 32'hC);
        chk("resume_count", fetch_count, 32'd3);
        chk("resume_pc4", if_id_pc_plus4, 32'hC);

        // Branch overrides stall
        step(0, 1, 1, 32'h40, 0, 0);
        chk("br_addr", imem_address, 32'h40);
        chk("br_inst", if_id_instruction, 32'h0);

        // Jump wins over branch
        step(0, 0, 1, 32'h40, 1, 32'h80);
        chk("jmp_addr", imem_address, 32'h80);

        // Misaligned jump faults and freezes until reset
        step(0, 0, 0, 0, 1, 32'h42);
        chk("fault_set", {31'b0, fetch_fault}, 32'h1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h10, 0, 0);
        chk("fault_hold_addr", imem_address, 32'h80);
        chk("fault_valid", {31'b0, if_id_valid}, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("fault_clr", {31'b0, fetch_fault}, 32'h0);

        // Out-of-range target faults too
        step(0, 0, 0, 0, 1, 32'h400);
        chk("range_fault", {31'b0, fetch_fault}, 32'h1);
        step(1, 0, 0, 0, 0, 0);

        // Wrap at top of memory
        step(0, 0, 0, 0, 1, 32'h3FC);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_addr", imem_address, 32'h0);
        chk("wrap_pc4", if_id_pc_plus4, 32'h400);
        chk("wrap_fault", {31'b0, fetch_fault}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 3, $urandom_range(99) < 25,
                 $urandom_range(99) < 10, rand_target(),
                 $urandom_range(99) < 6, rand_target());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
